uart_rx: RTL
============

Name: uart_rx

Overview:
- UART receiver, 8N1, LSB first. Consumer-side counterpart to uart_tx: converts the serial line back into bytes.
- Samples an asynchronous rx pin through a 2-flop synchronizer and qualifies the start bit at mid-bit.
- Samples each data bit and the stop bit at bit centres.
- Presents each received byte with a one-cycle valid strobe, or flags a framing error.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bit/s.
- BAUD_DIV is a localparam equal to CLK_FREQ/BAUD_RATE: clk cycles per bit. It must be at least 4.
- HALF_DIV is a localparam equal to BAUD_DIV/2, rounded down.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- rx_data  output  8  last correctly framed byte; held until the next good byte.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- rx_busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset: rst is sampled on the clk rising edge. Reset values:
  - rx_data=0x00, rx_valid=0, frame_err=0, rx_busy=0.
  - Both synchronizer flops = 1.
  - State = IDLE; bit counter and cycle counter = 0.
  - Reset mid-frame discards the partial byte, with no rx_valid and no frame_err.
- Synchronizer: rx_sync is rx delayed by 2 clk. All decisions use rx_sync only.
- Cycle counter: 32-bit, cleared on every state entry.
- States:
  - IDLE:
    - rx_sync==0: go to START, cnt=0.
    - Otherwise stay in IDLE.
  - START:
    - cnt increments each cycle.
    - At cnt==HALF_DIV-1, sample rx_sync.
    - Sample 0: go to DATA, cnt=0, bit_idx=0.
    - Sample 1: false start; return to IDLE with no pulse.
  - DATA:
    - At cnt==BAUD_DIV-1, shift rx_sync into shift_reg[7], shifting right so that the first bit ends at [0]. Then cnt=0 and bit_idx increments.
    - After the 8th sample (bit_idx==7), go to STOP.
  - STOP:
    - At cnt==BAUD_DIV-1, sample rx_sync.
    - Sample 1: rx_data<=shift_reg, rx_valid<=1 for exactly one cycle, go to IDLE.
    - Sample 0: frame_err<=1 for exactly one cycle, rx_data unchanged, go to WAIT_HIGH.
  - WAIT_HIGH:
    - Stay until rx_sync==1, then go to IDLE. This prevents a break or stuck-low line from being read as a stream of 0x00 frames.
- Sample points: bit n (n=0..7) is sampled HALF_DIV+(n+1)*BAUD_DIV cycles after START entry; the stop bit at HALF_DIV+9*BAUD_DIV.
- Back-to-back frames: IDLE is entered immediately after the stop-bit sample, so a start edge arriving in the second half of the stop bit is caught. No idle gap is required.
- No flow control:
  - rx_valid is not held.
  - A byte not captured by the consumer in the rx_valid cycle is overwritten by the next good frame.
- rx_valid and frame_err are never high in the same cycle.
- rx_busy is registered: it rises the cycle after START entry and falls the cycle after the return to IDLE.

Test Plan (bench uses CLK_FREQ=160, BAUD_RATE=10, so BAUD_DIV=16 and HALF_DIV=8; bit period 16 clk; rx driven by the bench):
1. Reset, then send 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop) -> one rx_valid pulse with rx_data=0xA5; frame_err stays 0; rx_busy low afterwards.
2. Send 0x00 then 0xFF with no idle gap between stop and next start -> two rx_valid pulses, rx_data=0x00 then 0xFF; pulses 160 cycles apart.
3. Drive rx low for 3 cycles, then high -> START entered, returns to IDLE; no rx_valid, no frame_err; a following 0x3C is received correctly.
4. Send 0x55 with the stop bit low, keep rx low 40 more cycles, then idle high and send 0x81 -> one frame_err pulse; rx_data stays at the previous value; no pulses while low; 0x81 received afterwards.
5. Assert rst during bit 4 of 0xC3, release, then send 0x12 -> all outputs at reset values; no pulse for the aborted byte; 0x12 received.
6. With a free-running uart_tx at identical default parameters driving rx, send 0x00..0xFF -> all 256 bytes received in order; no frame_err.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first. The rx pin is synchronised, the start bit is
// qualified at mid-bit, and data/stop bits are sampled at their centres.
module uart_rx #(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD_RATE = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       rx_busy
);

   // BAUD_DIV must be at least 4 for the half-bit qualification to make sense.
   localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
   localparam int HALF_DIV = BAUD_DIV / 2;
   localparam logic [31:0] BIT_LAST  = 32'(BAUD_DIV - 1);
   localparam logic [31:0] HALF_LAST = 32'(HALF_DIV - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;
   logic        busy_q;
   logic        rx_meta_q, rx_sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         busy_q    <= (state_q != IDLE);
      end
   end

   // The shift register holds only in-flight data; a partial byte is never
   // observable, so it needs no reset.
   always_ff @(posedge clk) begin
      shift_q <= shift_d;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 32'd1;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_sync_q) begin
               state_d = START;
            end
         end
         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (!rx_sync_q) begin
                  state_d   = DATA;
                  bit_idx_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               shift_d   = {rx_sync_q, shift_q[7:1]};
               cnt_d     = '0;
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (rx_sync_q) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            // A break must end before a new start edge can be recognised.
            cnt_d = '0;
            if (rx_sync_q) begin
               state_d = IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign frame_err = ferr_q;
   assign rx_busy   = busy_q;

endmodule
